calc_display: RTL and testbench

CALC_DISPLAY -- requirements
Module: calc_display

---
 rtl/calc_display_if.sv | 27 ++
 rtl/calc_display.sv | 180 ++++++++++++++++++
 tb/tb_calc_display.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_display_if.sv
// Calculator-to-display bus.
//   status/data/pos : calculator streaming a frame of BCD digits
//   an/seg          : active-low 8-digit seven-segment drive
//   frame_valid     : pulse, full frame committed to the display buffer
//   frame_drop      : pulse, incomplete frame discarded
//   err             : sticky error indicator
// master = calculator side, slave = display controller.
interface calc_display_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_valid;
  logic       frame_drop;
  logic       err;

  modport master (
    output status, data, pos,
    input  an, seg, frame_valid, frame_drop, err
  );

  modport slave (
    input  status, data, pos,
    output an, seg, frame_valid, frame_drop, err
  );
endinterface

// File: rtl/calc_display.sv
// Calculator result display controller.
// Captures a frame of eight BCD digits streamed by the calculator into a
// shadow buffer, commits it to the display buffer only when every position
// was written, and time-multiplexes the buffer onto an 8-digit
// seven-segment display with leading-zero blanking.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : calc_display_if slave modport (status/data/pos in,
//           an/seg/frame_valid/frame_drop/err out)
// Parameter:
//   REFRESH_DIV : clock cycles each digit stays selected (>= 2)
module calc_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic            clock,
  input logic            reset,
  calc_display_if.slave  bus
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [7:0][3:0] shadow_q;
  logic [7:0][3:0] buffer_q;
  logic [7:0]      written_q;
  logic            frame_valid_q;
  logic            frame_drop_q;
  logic            err_q;

  logic do_write;
  logic do_commit;
  logic do_drop;
  logic clear_mask;

  logic [CW-1:0] refresh_q;
  logic [2:0]    scan_q;
  logic [7:0]    an_q, an_n;
  logic [7:0]    seg_q, seg_n;

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    do_write   = 1'b0;
    do_commit  = 1'b0;
    do_drop    = 1'b0;
    clear_mask = 1'b0;
    unique case (state_q)
      IDLE, CAPTURE: begin
        if (bus.status == ST_ERROR) begin
          // partial frame is discarded silently, no drop pulse
          state_n    = ERROR;
          clear_mask = 1'b1;
        end else if (bus.status == ST_BUSY) begin
          state_n  = CAPTURE;
          do_write = ~bus.pos[3];
        end else if (bus.status == ST_READY && state_q == CAPTURE) begin
          state_n    = IDLE;
          clear_mask = 1'b1;
          if (written_q == 8'hFF) do_commit = 1'b1;
          else                    do_drop   = 1'b1;
        end
        // status 11: hold
      end
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q      <= '0;
      buffer_q      <= '0;
      written_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_valid_q <= do_commit;
      frame_drop_q  <= do_drop;
      if (state_n == ERROR) err_q <= 1'b1;
      if (do_write) begin
        shadow_q[bus.pos[2:0]]  <= bus.data;
        written_q[bus.pos[2:0]] <= 1'b1;
      end
      if (clear_mask) written_q <= '0;
      if (do_commit)  buffer_q  <= shadow_q;
    end
  end

  // ---------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_q <= '0;
      scan_q    <= '0;
    end else if (refresh_q == CW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      scan_q    <= scan_q + 3'd1;
    end else begin
      refresh_q <= refresh_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Digit decode
  // ---------------------------------------------------------------------
  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  logic [7:0] nonzero;
  logic [7:0] upper;
  logic       blank;

  always_comb begin
    nonzero = '0;
    for (int unsigned i = 0; i < 8; i++) nonzero[i] = |buffer_q[i];
    // digits at and above the selected one, shifted down to bit 0
    upper = nonzero >> scan_q;
    blank = (scan_q != 3'd0) && (upper == 8'h00);
    an_n  = ~(8'h01 << scan_q);
    if (err_q)      seg_n = (scan_q == 3'd0) ? 8'h86 : 8'hBF;
    else if (blank) seg_n = 8'hFF;
    else            seg_n = decode(buffer_q[scan_q]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_q  <= 8'hFE;
      seg_q <= 8'hC0;
    end else begin
      an_q  <= an_n;
      seg_q <= seg_n;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_drop  = frame_drop_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_calc_display.sv
module tb_calc_display;

  logic clock = 1'b0;
  logic reset = 1'b1;

  calc_display_if bus ();

  calc_display #(.REFRESH_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] digits;    // digit i at [4i+:4]
    int unsigned npos;      // positions 0..npos-1 streamed
    int unsigned mode;      // 0 plain, 1 pos=9 beats interleaved, 2 rewrite+hold
    logic        exp_valid; // 1 commit expected, 0 drop expected
    logic [63:0] exp_seg;   // expected seg for digit i at [8i+:8]
  } vec_t;

  vec_t vecs [7];

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic beat(input logic [3:0] p, input logic [3:0] d);
    bus.status = 2'b01;
    bus.pos    = p;
    bus.data   = d;
    tick();
  endtask

  task automatic stream(input vec_t v);
    logic [3:0] d;
    if (v.mode == 2) begin
      d = v.digits[3:0];
      beat(4'd0, ~d);
      bus.status = 2'b11;
      tick();
    end
    for (int i = 0; i < int'(v.npos); i++) begin
      beat(4'(i), v.digits[4*i +: 4]);
      if (v.mode == 1) beat(4'd9, 4'h7);
    end
  endtask

  task automatic commit(input string tag, output logic fv, output logic fd);
    bus.status = 2'b10;
    tick();
    fv = bus.frame_valid;
    fd = bus.frame_drop;
    tick();
    check({tag, " valid one-cycle"}, {63'd0, bus.frame_valid}, 64'd0);
    check({tag, " drop one-cycle"},  {63'd0, bus.frame_drop},  64'd0);
  endtask

  task automatic read_digit(input int i, output logic [7:0] s, output bit ok);
    logic [7:0] want;
    want = ~(8'h01 << i);
    ok = 1'b0;
    s  = 8'h00;
    for (int n = 0; n < 64; n++) begin
      if (bus.an === want) begin
        s  = bus.seg;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic check_display(input string tag, input logic [63:0] exp);
    logic [7:0] s;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      read_digit(i, s, ok);
      if (!ok) check($sformatf("%s d%0d select timeout", tag, i), 64'd0, 64'd1);
      else     check($sformatf("%s d%0d", tag, i), {56'd0, s}, {56'd0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    logic       fv, fd;
    logic [7:0] prev;
    int         cyc;

    vecs[0] = '{digits: 32'h0000_0125, npos: 8, mode: 0, exp_valid: 1'b1,
                exp_seg: 64'hFFFF_FFFF_FFF9_A492};
    vecs[1] = '{digits: 32'h9999_9999, npos: 6, mode: 0, exp_valid: 1'b0,
                exp_seg: 64'hFFFF_FFFF_FFF9_A492};
    vecs[2] = '{digits: 32'h0000_0000, npos: 8, mode: 1, exp_valid: 1'b1,
                exp_seg: 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[3] = '{digits: 32'h0000_C001, npos: 8, mode: 0, exp_valid: 1'b1,
                exp_seg: 64'hFFFF_FFFF_BFC0_C0F9};
    vecs[4] = '{digits: 32'h7654_3210, npos: 8, mode: 2, exp_valid: 1'b1,
                exp_seg: 64'hF882_9299_B0A4_F9C0};
    vecs[5] = '{digits: 32'h0000_AF98, npos: 8, mode: 0, exp_valid: 1'b1,
                exp_seg: 64'hFFFF_FFFF_BFBF_9080};
    vecs[6] = '{digits: 32'h9999_9999, npos: 8, mode: 0, exp_valid: 1'b1,
                exp_seg: 64'h9090_9090_9090_9090};

    bus.status = 2'b10;
    bus.pos    = 4'd0;
    bus.data   = 4'd0;

    // reset for two cycles, then scan timing with REFRESH_DIV=4
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post-reset an", {56'd0, bus.an}, {56'd0, 8'hFE});
    check("post-reset seg", {56'd0, bus.seg}, {56'd0, 8'hC0});
    check("post-reset err", {63'd0, bus.err}, 64'd0);
    check("post-reset valid", {63'd0, bus.frame_valid}, 64'd0);
    check("post-reset drop", {63'd0, bus.frame_drop}, 64'd0);
    tick(); tick(); tick();
    check("digit0 held 4 cycles", {56'd0, bus.an}, {56'd0, 8'hFE});
    tick();
    check("first advance an", {56'd0, bus.an}, {56'd0, 8'hFD});
    check("first advance seg blank", {56'd0, bus.seg}, {56'd0, 8'hFF});

    // scan order incl. 7->0 wrap, one step every 4 cycles
    prev = bus.an;
    cyc  = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      cyc++;
      if (bus.an !== prev) begin
        check("scan step", {56'd0, bus.an}, {56'd0, prev[6:0], prev[7]});
        check("scan period", 64'(cyc), 64'd4);
        prev = bus.an;
        cyc  = 0;
      end
    end

    // table-driven frames
    for (int k = 0; k < 7; k++) begin
      stream(vecs[k]);
      commit($sformatf("vec%0d", k), fv, fd);
      check($sformatf("vec%0d frame_valid", k), {63'd0, fv}, {63'd0, vecs[k].exp_valid});
      check($sformatf("vec%0d frame_drop", k), {63'd0, fd}, {63'd0, ~vecs[k].exp_valid});
      check_display($sformatf("vec%0d", k), vecs[k].exp_seg);
    end

    // reset in the middle of a full capture: no pulses, buffer cleared
    stream(vecs[4]);
    bus.status = 2'b10;
    reset = 1'b1;
    tick();
    check("mid-capture reset valid", {63'd0, bus.frame_valid}, 64'd0);
    check("mid-capture reset drop", {63'd0, bus.frame_drop}, 64'd0);
    reset = 1'b0;
    tick();
    check("after reset valid", {63'd0, bus.frame_valid}, 64'd0);
    check("after reset drop", {63'd0, bus.frame_drop}, 64'd0);
    check("after reset an", {56'd0, bus.an}, {56'd0, 8'hFE});
    check("after reset seg", {56'd0, bus.seg}, {56'd0, 8'hC0});
    check_display("cleared", 64'hFFFF_FFFF_FFFF_FFC0);

    // load a known frame, then error mid-stream
    stream(vecs[0]);
    commit("pre-error", fv, fd);
    check("pre-error frame_valid", {63'd0, fv}, 64'd1);
    for (int i = 0; i < 4; i++) beat(4'(i), 4'd3);
    bus.status = 2'b00;
    tick();
    check("error err", {63'd0, bus.err}, 64'd1);
    check("error no drop", {63'd0, bus.frame_drop}, 64'd0);
    bus.status = 2'b10;
    tick();
    check("error status10 no drop", {63'd0, bus.frame_drop}, 64'd0);
    check("error status10 no valid", {63'd0, bus.frame_valid}, 64'd0);
    check_display("error", 64'hBFBF_BFBF_BFBF_BF86);

    // frames after error are ignored
    stream(vecs[6]);
    commit("in-error", fv, fd);
    check("in-error frame_valid", {63'd0, fv}, 64'd0);
    check("in-error frame_drop", {63'd0, fd}, 64'd0);
    check("in-error err sticky", {63'd0, bus.err}, 64'd1);
    check_display("still error", 64'hBFBF_BFBF_BFBF_BF86);

    // reset leaves ERROR
    reset = 1'b1;
    tick();
    check("reset in error valid", {63'd0, bus.frame_valid}, 64'd0);
    check("reset in error drop", {63'd0, bus.frame_drop}, 64'd0);
    reset = 1'b0;
    tick();
    check("error cleared", {63'd0, bus.err}, 64'd0);
    check("error cleared an", {56'd0, bus.an}, {56'd0, 8'hFE});
    check("error cleared seg", {56'd0, bus.seg}, {56'd0, 8'hC0});
    stream(vecs[3]);
    commit("post-error", fv, fd);
    check("post-error frame_valid", {63'd0, fv}, 64'd1);
    check_display("post-error", vecs[3].exp_seg);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
